// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//
// Contents:
//   DEF_XLEN      default address/data width
//   INSTR_W       instruction word width
//   PC_INC        sequential PC increment
//   DEF_RESET_PC  default PC driven while in reset
//   fetch_entry_t {pc, instr} pair buffered between memory and decode
//   cnt_w()       width of an occupancy counter able to hold 0..depth
package rv_fetch_pkg;

  localparam int                    DEF_XLEN     = 32;
  localparam int                    INSTR_W      = 32;
  localparam int unsigned           PC_INC       = 4;
  localparam logic [DEF_XLEN-1:0]   DEF_RESET_PC = '0;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

  // A counter for a power-of-two depth must also represent "full".
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with a registered head.
//
// The head word is held in its own register so the consumer sees a flop
// output rather than a read-mux of the storage array. A push into an empty
// FIFO (or into one being emptied by a same-cycle pop) lands directly in the
// head register, so data is visible the cycle after it is pushed.
//
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   flush      discard all contents (dominates push/pop)
//   push       write push_data (ignored when full unless popping)
//   push_data  word to write
//   pop        remove the head (ignored when empty)
//   count      current occupancy, 0..DEPTH
//   head       oldest entry; all zeros when empty
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int W     = $bits(fetch_entry_t),
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q < DEPTH_C) || pop_ok);
    rd_next  = rd_ptr_q + AW'(1);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_next;
      end
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      // The new head is the pushed word when it becomes the only entry,
      // otherwise the entry behind the popped one.
      if (count_d == '0) begin
        head_d = '0;
      end else if (push_ok && ((count_q == '0) ||
                               (pop_ok && (count_q == (AW+1)'(1))))) begin
        head_d = push_data;
      end else if (pop_ok) begin
        head_d = mem_q[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset: nothing reads it unless count says it is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage wrapped around the PC register.
//
// Issues in-order instruction-memory requests at PC, tags each returning
// word with its PC, buffers {pc, instr} in a small FIFO and presents it to
// decode. A redirect flushes the buffer and discards every response that was
// already in flight.
//
// Handshakes (both request and decode sides): a transfer happens on a rising
// edge where valid && ready are both 1. valid never depends on ready; the
// presenting side holds its payload stable while valid && !ready.
//
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds output if_misalign.
// A redirect to a target with nonzero low two bits then sets it (sticky
// until reset) and halts fetch with PC_Next parked on the bad target.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   PC / PC_Next     current PC in, next PC out (to the PC register)
//   redirect_valid   redirect request; redirect_pc is the target
//   imem_req_*       request channel; address is PC
//   imem_rsp_*       in-order responses, latency >= 1 cycle
//   if_valid/ready   decode handshake; if_pc/if_instr are the payload
//   if_misalign      (macro only) sticky misaligned-redirect flag
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    PC,
  output logic [XLEN-1:0]    PC_Next,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               if_misalign
`endif
);

  localparam int            CW      = cnt_w(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]  fifo_count, pcq_count;
  logic [CW:0]    credit_used;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t   rsp_entry, if_head;
  logic           can_req, req_fire, rsp_ok, rsp_keep, halt;

  // Every buffered entry and every in-flight request (stale ones included)
  // holds a credit, so the instruction FIFO can never overflow.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};

  always_comb begin
    can_req        = rst && !redirect_valid && !halt && (credit_used < DEPTH_C);
    imem_req_valid = can_req;
    imem_req_addr  = PC;
    req_fire       = can_req && imem_req_ready;
    // A response with nothing outstanding cannot be ours; ignore it.
    rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
    rsp_keep       = rsp_ok && !redirect_valid && (drop_cnt_q == '0) &&
                     (pcq_count != '0);
    outstanding_d  = outstanding_q + CW'(req_fire) - CW'(rsp_ok);

    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // No request issues this cycle, so whatever is still outstanding after
      // this edge belongs to the old path and must be discarded.
      drop_cnt_d = outstanding_q - CW'(rsp_ok);
    end else if (rsp_ok && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (!rst) begin
      PC_Next = RESET_PC;
    end else if (halt) begin
      PC_Next = PC;
    end else if (redirect_valid) begin
      PC_Next = redirect_pc;
    end else if (req_fire) begin
      PC_Next = PC + XLEN'(PC_INC);
    end else begin
      PC_Next = PC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign halt        = misalign_q;
  assign if_misalign = misalign_q;
`else
  assign halt = 1'b0;
`endif

  // PCs of live requests in issue order; its head tags the next response.
  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (PC),
    .pop       (rsp_keep),
    .count     (pcq_count),
    .head      (pcq_head)
  );

  assign rsp_entry = '{pc: pcq_head, instr: imem_rsp_data};

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (if_valid && if_ready),
    .count     (fifo_count),
    .head      (if_head)
  );

  assign if_valid = (fifo_count != '0);
  assign if_pc    = if_head.pc;
  assign if_instr = if_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. The bench owns the PC register and an in-order
// memory model; a reference model of credits, drops and buffering predicts
// requests, PC_Next and the decode stream each cycle.
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, PC_Next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_misalign;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .PC_Next        (PC_Next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .if_misalign    (if_misalign)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          checks;
  int          failures;
  int          cyc;
  int          lat_min, lat_max;
  int          req_cnt;
  logic [31:0] first_req_addr;
  logic [63:0] exp_q[$];      // expected {pc, instr} buffered for decode
  logic [31:0] inf_addr[$];   // in-flight memory requests
  int          inf_due[$];
  bit          inf_live[$];
  logic [31:0] pop_log[$];
  bit          halted;

  logic        s_req_valid, s_if_valid, s_misalign;
  logic [31:0] s_pcn, s_if_pc, s_if_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  // ---------------- driver + monitor: one clock cycle ----------------
  task automatic cycle();
    logic [31:0] exp_pcn, a;
    logic [63:0] e;
    bit          exp_can, fire, live;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_pcn       = PC_Next;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_instr  = if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    s_misalign  = if_misalign;
    checks++;
    if (if_misalign !== halted) begin
      failures++;
      $display("FAIL misalign cyc=%0d: got %b expected %b", cyc, if_misalign, halted);
    end
`else
    s_misalign  = 1'b0;
`endif
    exp_can = rst && !redirect_valid && !halted &&
              ((inf_addr.size() + exp_q.size()) < DEPTH);
    checks++;
    if (imem_req_valid !== exp_can) begin
      failures++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_can);
    end
    if (exp_can) begin
      checks++;
      if (imem_req_addr !== PC) begin
        failures++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, PC);
      end
    end
    checks++;
    if (if_valid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL if_valid cyc=%0d: got %b expected %b", cyc, if_valid, exp_q.size() != 0);
    end
    fire = exp_can && imem_req_ready;
    if (!rst)                exp_pcn = RST_PC;
    else if (halted)         exp_pcn = PC;
    else if (redirect_valid) exp_pcn = redirect_pc;
    else if (fire)           exp_pcn = PC + 32'd4;
    else                     exp_pcn = PC;
    checks++;
    if (PC_Next !== exp_pcn) begin
      failures++;
      $display("FAIL pc_next cyc=%0d: got %h expected %h", cyc, PC_Next, exp_pcn);
    end

    if (!rst) begin
      exp_q.delete();
      inf_addr.delete();
      inf_due.delete();
      inf_live.delete();
      halted = 1'b0;
    end else begin
      if ((exp_q.size() != 0) && if_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({if_pc, if_instr} !== e) begin
          failures++;
          $display("FAIL decode cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                   cyc, if_pc, if_instr, e[63:32], e[31:0]);
        end
        pop_log.push_back(if_pc);
      end
      if (imem_rsp_valid && (inf_addr.size() != 0)) begin
        a    = inf_addr.pop_front();
        live = inf_live.pop_front();
        void'(inf_due.pop_front());
        if (live && !redirect_valid) exp_q.push_back({a, mem_word(a)});
      end
      if (redirect_valid) begin
        exp_q.delete();
        for (int i = 0; i < inf_live.size(); i++) inf_live[i] = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`endif
      end
      if (fire) begin
        inf_addr.push_back(PC);
        inf_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        inf_live.push_back(1'b1);
        if (req_cnt == 0) first_req_addr = PC;
        req_cnt++;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    PC             = exp_pcn;
    imem_rsp_valid = (inf_addr.size() != 0) && (inf_due[0] <= cyc);
    imem_rsp_data  = imem_rsp_valid ? mem_word(inf_addr[0]) : $urandom;
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    lat_min        = 1;
    lat_max        = 1;
    repeat (n) cycle();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) begin
      cycle();
      checks++;
      if (s_if_valid !== 1'b0 || s_if_pc !== 32'h0 || s_if_instr !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs: got v=%b pc=%h instr=%h expected 0/0/0",
                 s_if_valid, s_if_pc, s_if_instr);
      end
      checks++;
      if (s_req_valid !== 1'b0 || s_pcn !== RST_PC) begin
        failures++;
        $display("FAIL reset_req: got req=%b pcn=%h expected 0/%h", s_req_valid, s_pcn, RST_PC);
      end
    end
  endtask

  task automatic test_stream();
    bit ok;
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    pop_log.delete();
    cycle();
    checks++;
    if (s_req_valid !== 1'b1 || s_pcn !== 32'h4) begin
      failures++;
      $display("FAIL stream_first: got req=%b pcn=%h expected 1/00000004", s_req_valid, s_pcn);
    end
    cycle();
    checks++;
    if (s_pcn !== 32'h8) begin
      failures++;
      $display("FAIL stream_second: got pcn=%h expected 00000008", s_pcn);
    end
    cycle();
    checks++;
    if (s_if_valid !== 1'b1 || s_if_pc !== 32'h0 || s_if_instr !== 32'h13) begin
      failures++;
      $display("FAIL stream_latency: got v=%b pc=%h instr=%h expected 1/0/00000013",
               s_if_valid, s_if_pc, s_if_instr);
    end
    repeat (10) cycle();
    ok = (pop_log.size() >= 3);
    if (ok) ok = (pop_log[0] == 32'h0) && (pop_log[1] == 32'h4) && (pop_log[2] == 32'h8);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stream_order: got %0d pops expected pcs 0,4,8 first", pop_log.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    req_cnt        = 0;
    repeat (8) cycle();
    checks++;
    if (req_cnt != 2 || s_req_valid !== 1'b0 || s_pcn !== 32'h8) begin
      failures++;
      $display("FAIL bp_fill: got reqs=%0d req=%b pcn=%h expected 2/0/00000008",
               req_cnt, s_req_valid, s_pcn);
    end
    if_ready = 1'b1;
    req_cnt  = 0;
    pop_log.delete();
    repeat (6) cycle();
    ok = (pop_log.size() >= 2);
    if (ok) ok = (pop_log[0] == 32'h0) && (pop_log[1] == 32'h4);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_drain: got %0d pops expected pcs 0,4 first", pop_log.size());
    end
    checks++;
    if (req_cnt == 0 || first_req_addr !== 32'h8) begin
      failures++;
      $display("FAIL bp_resume: got reqs=%0d addr=%h expected >0/00000008", req_cnt, first_req_addr);
    end
  endtask

  task automatic test_redirect_stale();
    bit ok;
    do_reset(1);
    if_ready       = 1'b1;
    lat_min        = 3;
    lat_max        = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    req_cnt        = 0;
    repeat (2) cycle();
    checks++;
    if (req_cnt != 2 || first_req_addr !== 32'h10) begin
      failures++;
      $display("FAIL stale_issue: got reqs=%0d first=%h expected 2/00000010", req_cnt, first_req_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    pop_log.delete();
    repeat (15) cycle();
    ok = (pop_log.size() != 0);
    if (ok) ok = (pop_log[0] == 32'h100);
    for (int i = 0; i < pop_log.size(); i++)
      if (pop_log[i] == 32'h10 || pop_log[i] == 32'h14) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stale_drop: got %0d pops, first=%h expected first 00000100 and no stale",
               pop_log.size(), (pop_log.size() != 0) ? pop_log[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    for (int i = 0; i < 10 && !imem_rsp_valid; i++) cycle();
    checks++;
    if (imem_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL collide_setup: got rsp_valid=%b expected 1", imem_rsp_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (s_req_valid !== 1'b0 || s_pcn !== 32'h200) begin
      failures++;
      $display("FAIL collide_cycle: got req=%b pcn=%h expected 0/00000200", s_req_valid, s_pcn);
    end
    pop_log.delete();
    repeat (8) cycle();
    ok = (pop_log.size() != 0);
    if (ok) ok = (pop_log[0] == 32'h200);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL collide_after: got %0d pops expected first pc 00000200", pop_log.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    checks++;
    if (s_req_valid !== 1'b1 || s_pcn !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pcn: got req=%b pcn=%h expected 1/00000000", s_req_valid, s_pcn);
    end
    pop_log.delete();
    repeat (6) cycle();
    ok = (pop_log.size() >= 2);
    if (ok) ok = (pop_log[0] == 32'hFFFF_FFFC) && (pop_log[1] == 32'h0);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_order: got %0d pops expected fffffffc then 00000000", pop_log.size());
    end
  endtask

  task automatic test_random();
    do_reset(1);
    lat_min = 1;
    lat_max = 4;
    pop_log.delete();
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 32'($urandom_range(0, 16383)) << 2;
      cycle();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    repeat (12) cycle();
    checks++;
    if (pop_log.size() < 20 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: got pops=%0d left=%0d expected >=20/0", pop_log.size(), exp_q.size());
    end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset(1);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (s_pcn !== 32'h102) begin
      failures++;
      $display("FAIL misalign_target: got pcn=%h expected 00000102", s_pcn);
    end
    repeat (4) begin
      cycle();
      checks++;
      if (s_req_valid !== 1'b0 || s_misalign !== 1'b1 || s_pcn !== 32'h102) begin
        failures++;
        $display("FAIL misalign_halt: got req=%b mis=%b pcn=%h expected 0/1/00000102",
                 s_req_valid, s_misalign, s_pcn);
      end
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (s_pcn !== RST_PC) begin
      failures++;
      $display("FAIL misalign_reset_pc: got %h expected %h", s_pcn, RST_PC);
    end
    cycle();
    checks++;
    if (s_misalign !== 1'b0) begin
      failures++;
      $display("FAIL misalign_clear: got %b expected 0", s_misalign);
    end
    rst = 1'b1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    req_cnt        = 0;
    first_req_addr = '0;
    halted         = 1'b0;
    lat_min        = 1;
    lat_max        = 1;
    rst            = 1'b0;
    PC             = RST_PC;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collide();
    test_wrap();
    test_random();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
